// File: rtl/io_pkg.sv
// Shared types and default parameters for the switch sampler.
package io_pkg;

  // Per-channel debounce state
  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } sw_state_e;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_DEBOUNCE_CYC = 16;
  localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: input synchroniser, debounce FSM with counter,
// debounced level and registered rise/fall pulses.
module sw_debounce_ch
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic sw_raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  // The counter records how many consecutive differing samples have been
  // seen; the sample that makes it DEBOUNCE_CYC is the accepting one, so a
  // step lands on the output SYNC_STAGES+DEBOUNCE_CYC edges after capture.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced;
  logic                   differs;
  sw_state_e              state_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   stable_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  // Shift the raw level through the synchroniser chain
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) sync_reg <= '0;
    else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_raw};
  end

  assign synced  = sync_reg[SYNC_STAGES-1];
  assign differs = (synced != stable_reg);
  // High in the cycle whose edge flips the debounced level
  assign accept  = (state_reg == SETTLING) && differs && (cnt_reg == LAST_CNT);

  // Debounce FSM: count a held new level, drop it on any glitch back
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg  <= STABLE;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        STABLE: begin
          if (differs) begin
            state_reg <= SETTLING;
            cnt_reg   <= CW'(1);
          end
        end
        SETTLING: begin
          if (!differs) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end else if (accept) begin
            stable_reg <= ~stable_reg;
            rise_reg   <= ~stable_reg;
            fall_reg   <= stable_reg;
            cnt_reg    <= '0;
            state_reg  <= STABLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

endmodule

// File: rtl/io_sw_sampler.sv
// Multi-channel debounced switch sampler with sticky change flags and a
// maskable interrupt request.
module io_sw_sampler
  import io_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_io_sw,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_ack_mask,
  input  logic [WIDTH-1:0] i_irq_mask,
  output logic [WIDTH-1:0] o_sw_stable,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic [WIDTH-1:0] o_change,
  output logic             o_irq
);

  logic [WIDTH-1:0] accept_vec;
  logic [WIDTH-1:0] clear_vec;
  logic [WIDTH-1:0] change_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      sw_debounce_ch #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .sw_raw (i_io_sw[gi]),
        .stable (o_sw_stable[gi]),
        .rise   (o_sw_rise[gi]),
        .fall   (o_sw_fall[gi]),
        .accept (accept_vec[gi])
      );
    end
  endgenerate

  assign clear_vec = i_ack ? i_ack_mask : '0;

  // Sticky change flags; a new acceptance beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) change_reg <= '0;
    else          change_reg <= (change_reg & ~clear_vec) | accept_vec;
  end

  assign o_change = change_reg;
  assign o_irq    = |(change_reg & i_irq_mask);

endmodule

// File: doc/io_sw_sampler.md
IO_SW_SAMPLER -- requirements
Module: io_sw_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of switch channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 16: consecutive cycles a new level must hold before acceptance (2..65535).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (2..4).
REQ-004 SHALL have port i_clk, input, 1: single clock; all flops on rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_io_sw, input, WIDTH: raw asynchronous switch levels.
REQ-007 SHALL have port i_ack, input, 1: clear strobe for change flags.
REQ-008 SHALL have port i_ack_mask, input, WIDTH: channels cleared when i_ack=1.
REQ-009 SHALL have port i_irq_mask, input, WIDTH: per-channel interrupt enable.
REQ-010 SHALL have port o_sw_stable, output, WIDTH: debounced switch levels.
REQ-011 SHALL have port o_sw_rise, output, WIDTH: one-cycle pulse on accepted 0->1.
REQ-012 SHALL have port o_sw_fall, output, WIDTH: one-cycle pulse on accepted 1->0.
REQ-013 SHALL have port o_change, output, WIDTH: sticky per-channel change flags.
REQ-014 SHALL have port o_irq, output, 1: interrupt request.

Function
REQ-015 Each channel SHALL pass i_io_sw through SYNC_STAGES flops before any other logic.
REQ-016 Each channel SHALL run an FSM with states STABLE and SETTLING plus a counter of $clog2(DEBOUNCE_CYC+1) bits.
REQ-017 STABLE: synced value equals stable value. Synced differs -> SETTLING, counter=1.
REQ-018 SETTLING, synced still differs, counter<DEBOUNCE_CYC -> counter+1.
REQ-019 SETTLING, synced still differs, counter==DEBOUNCE_CYC -> stable value inverts, counter=0, -> STABLE.
REQ-020 SETTLING, synced equals stable (glitch) -> counter=0, -> STABLE; no output change.
REQ-021 A held input step SHALL reach o_sw_stable SYNC_STAGES+DEBOUNCE_CYC cycles after the first edge sampling it.
REQ-022 o_sw_rise/o_sw_fall SHALL be registered, asserted exactly in the cycle o_sw_stable first shows the new value, for one cycle.
REQ-023 o_change[i] SHALL set in the cycle o_sw_stable[i] changes; set SHALL persist until cleared.
REQ-024 i_ack=1 SHALL clear o_change[i] for every i with i_ack_mask[i]=1 on the next edge.
REQ-025 Simultaneous set and clear on the same bit SHALL leave it set (set wins).
REQ-026 o_irq SHALL be combinational: OR over (o_change & i_irq_mask).
REQ-027 Channels SHALL be fully independent; simultaneous events on many channels SHALL all be captured.

Reset
REQ-028 i_reset low SHALL immediately zero synchroniser flops, counters, o_sw_stable, o_sw_rise, o_sw_fall, o_change; all FSMs -> STABLE; o_irq thus 0.
REQ-029 Reset asserted mid-SETTLING SHALL discard progress; after release, a full SYNC_STAGES+DEBOUNCE_CYC count SHALL be required.
REQ-030 After release, input levels of 1 SHALL be accepted as normal rises (rise pulse, change flag set).

Structure
REQ-031 Package io_pkg SHALL hold the sw_state_e enum (STABLE, SETTLING) and default parameter constants.
REQ-032 One sub-module sw_debounce_ch (synchroniser, FSM, counter, stable bit, pulses) SHALL be instantiated WIDTH times via generate; top holds change flags and irq.

Verification (WIDTH=4, DEBOUNCE_CYC=4, SYNC_STAGES=2)
REQ-033 Release reset, i_io_sw=4'hA held -> o_sw_stable=4'hA on 6th edge, o_sw_rise=4'hA for one cycle, o_change=4'hA.
REQ-034 Bit0 high 3 cycles then low -> o_sw_stable, pulses, o_change stay 0.
REQ-035 o_change=4'hA, i_ack=1, i_ack_mask=4'h2 one cycle -> o_change=4'h8.
REQ-036 Bit1 change accepted in same cycle as i_ack with mask 4'h2 -> o_change[1] remains 1.
REQ-037 i_reset low at counter=2 -> all outputs 0 immediately; after release, acceptance exactly 6 edges later.
REQ-038 i_irq_mask=4'h8, bit3 falls after 4'hA accepted and acked -> o_sw_fall=4'h8 pulse, o_irq=1 until ack with mask 4'h8.
